// File: rtl/pong_input_sched.sv
// Input scheduler for the pong core: serialises four credit/start request
// sources into fixed-length coin_sw pulses and drives both paddle positions.
module pong_input_sched #(
  parameter int PULSE_CYC = 358000,
  parameter int GAP_CYC   = 1432000,
  parameter int STEP_DIV  = 11932,
  parameter int ANA_THR   = 16
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [7:0] ana0,
  input  logic [7:0] ana1,
  input  logic [1:0] dig_up,
  input  logic [1:0] dig_dn,
  output logic       coin_sw,
  output logic       busy,
  output logic [1:0] grant_id,
  output logic [1:0] dig_mode,
  output logic [7:0] paddle1_vpos,
  output logic [7:0] paddle2_vpos
);

  localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIV_W   = $clog2(STEP_DIV + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]         r_pending, w_pending_nxt;
  logic [3:0]         r_req_prev;
  logic [1:0]         r_grant, w_grant_nxt;
  logic [3:0]         w_edge;
  logic [3:0]         w_req_all;
  logic [1:0]         w_sel;

  assign w_edge    = req & ~r_req_prev;
  assign w_req_all = r_pending | w_edge;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours, regardless of block order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pending  <= '0;
      r_grant    <= '0;
      r_req_prev <= req;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pending  <= w_pending_nxt;
      r_grant    <= w_grant_nxt;
      r_req_prev <= req;
    end
  end

  // Lowest set index wins; scanning downwards lets the last hit be bit 0.
  always_comb begin
    w_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_req_all[i]) w_sel = 2'(i);
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = w_req_all;
    w_grant_nxt   = r_grant;
    case (r_state)
      S_IDLE: begin
        if (|w_req_all) begin
          w_grant_nxt   = w_sel;
          w_pending_nxt = w_req_all & ~(4'b0001 << w_sel);
          w_state_nxt   = S_PULSE;
          w_cnt_nxt     = '0;
        end
      end
      S_PULSE: begin
        if (r_cnt == CNT_W'(PULSE_CYC - 1)) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign coin_sw  = (r_state == S_PULSE);
  assign busy     = (r_state != S_IDLE);
  assign grant_id = r_grant;

  // Free-running step divider paces the digital paddle ramp.
  logic [DIV_W-1:0] r_div;
  logic             w_tick;

  assign w_tick = (r_div == DIV_W'(STEP_DIV - 1));

  always_ff @(posedge clk_sys) begin
    if (reset)       r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + DIV_W'(1);
  end

  logic [7:0] r_pos     [2];
  logic [7:0] r_ana_ref [2];
  logic [1:0] r_dig_mode;
  logic [7:0] w_ana     [2];
  logic [8:0] w_diff    [2];
  logic [8:0] w_abs     [2];
  logic [1:0] w_far;
  logic [1:0] w_btn;

  assign w_ana[0] = ana0;
  assign w_ana[1] = ana1;
  assign w_btn    = dig_up | dig_dn;

  // Bit 8 of the 9-bit difference is the sign; magnitude never exceeds 255.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      w_diff[n] = {1'b0, w_ana[n]} - {1'b0, r_ana_ref[n]};
      w_abs[n]  = w_diff[n][8] ? (~w_diff[n] + 9'd1) : w_diff[n];
      w_far[n]  = (w_abs[n] >= 9'(ANA_THR));
    end
  end

  // NOTE: these small arrays are plain flops rather than a RAM, so they are
  // reset like any other register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int n = 0; n < 2; n++) begin
        r_pos[n]     <= 8'h80;
        r_ana_ref[n] <= 8'h00;
      end
      r_dig_mode <= 2'b00;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (!r_dig_mode[n]) begin
          if (w_btn[n]) begin
            r_dig_mode[n] <= 1'b1;
            r_ana_ref[n]  <= w_ana[n];
          end else begin
            r_pos[n] <= w_ana[n];
          end
        end else if (w_btn[n]) begin
          r_ana_ref[n] <= w_ana[n];
          if (w_tick) begin
            if (dig_up[n] && !dig_dn[n]) begin
              if (r_pos[n] != 8'h00) r_pos[n] <= r_pos[n] - 8'd1;
            end else if (dig_dn[n] && !dig_up[n]) begin
              if (r_pos[n] != 8'hFF) r_pos[n] <= r_pos[n] + 8'd1;
            end
          end
        end else if (w_far[n]) begin
          r_dig_mode[n] <= 1'b0;
        end
      end
    end
  end

  assign dig_mode     = r_dig_mode;
  assign paddle1_vpos = r_pos[0];
  assign paddle2_vpos = r_pos[1];

endmodule

// File: tb/tb_pong_input_sched.sv
// Scoreboard bench for pong_input_sched: a cycle-level reference model queues
// expected pulses and paddle states, a negedge monitor compares them.
module tb_pong_input_sched;

  localparam int P   = 4;
  localparam int G   = 3;
  localparam int SD  = 2;
  localparam int THR = 16;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic [3:0] req     = 4'b0000;
  logic [7:0] ana0    = 8'h80;
  logic [7:0] ana1    = 8'h80;
  logic [1:0] dig_up  = 2'b00;
  logic [1:0] dig_dn  = 2'b00;
  logic       coin_sw;
  logic       busy;
  logic [1:0] grant_id;
  logic [1:0] dig_mode;
  logic [7:0] paddle1_vpos;
  logic [7:0] paddle2_vpos;

  pong_input_sched #(
    .PULSE_CYC(P), .GAP_CYC(G), .STEP_DIV(SD), .ANA_THR(THR)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .req         (req),
    .ana0        (ana0),
    .ana1        (ana1),
    .dig_up      (dig_up),
    .dig_dn      (dig_dn),
    .coin_sw     (coin_sw),
    .busy        (busy),
    .grant_id    (grant_id),
    .dig_mode    (dig_mode),
    .paddle1_vpos(paddle1_vpos),
    .paddle2_vpos(paddle2_vpos)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int grant;
    int start;
  } pulse_t;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] p0;
    logic [7:0] p1;
  } pad_t;

  pulse_t exp_pulses[$];
  pad_t   exp_pads[$];
  int     cyc   = 0;
  int     rises = 0;

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Reference model: the core is free again P+G+1 edges after a grant; credits
  // are a 4-bit set; paddles follow the mode/ramp rules with plain integers.
  initial begin
    int         free_at;
    int         n_since;
    logic [3:0] m_prev, m_credit, e, all;
    bit         m_mode [2];
    int         m_pos  [2];
    int         m_ref  [2];
    free_at  = 0;
    n_since  = 0;
    m_prev   = '0;
    m_credit = '0;
    for (int n = 0; n < 2; n++) begin
      m_mode[n] = 0; m_pos[n] = 128; m_ref[n] = 0;
    end
    forever begin
      @(posedge clk_sys);
      cyc++;
      if (reset) begin
        m_prev   = req;
        m_credit = '0;
        free_at  = 0;
        n_since  = 0;
        exp_pulses.delete();
        for (int n = 0; n < 2; n++) begin
          m_mode[n] = 0; m_pos[n] = 128; m_ref[n] = 0;
        end
      end else begin
        bit tick;
        e      = req & ~m_prev;
        m_prev = req;
        if (cyc >= free_at) begin
          all = m_credit | e;
          if (all != 0) begin
            pulse_t pe;
            pe.grant = lowest(all);
            pe.start = cyc;
            exp_pulses.push_back(pe);
            m_credit = all & ~(4'b0001 << pe.grant);
            free_at  = cyc + P + G + 1;
          end
        end else begin
          m_credit = m_credit | e;
        end
        tick = ((n_since % SD) == SD - 1);
        n_since++;
        for (int n = 0; n < 2; n++) begin
          bit up, dn;
          int a, d;
          up = dig_up[n];
          dn = dig_dn[n];
          a  = (n == 0) ? int'(ana0) : int'(ana1);
          d  = a - m_ref[n];
          if (d < 0) d = -d;
          if (!m_mode[n]) begin
            if (up || dn) begin
              m_mode[n] = 1;
              m_ref[n]  = a;
            end else begin
              m_pos[n] = a;
            end
          end else if (up || dn) begin
            m_ref[n] = a;
            if (tick && up && !dn && m_pos[n] > 0)   m_pos[n] = m_pos[n] - 1;
            if (tick && dn && !up && m_pos[n] < 255) m_pos[n] = m_pos[n] + 1;
          end else if (d >= THR) begin
            m_mode[n] = 0;
          end
        end
      end
      begin
        pad_t pp;
        pp.mode = {m_mode[1], m_mode[0]};
        pp.p0   = 8'(m_pos[0]);
        pp.p1   = 8'(m_pos[1]);
        exp_pads.push_back(pp);
      end
    end
  end

  // Monitor: compares paddles every cycle and each coin pulse as it appears.
  initial begin
    bit prev_coin;
    int hi_len;
    int low_len;
    prev_coin = 0;
    hi_len    = 0;
    low_len   = -1;
    forever begin
      @(negedge clk_sys);
      if (exp_pads.size() > 0) begin
        pad_t pp;
        pp = exp_pads.pop_front();
        check("dig_mode", dig_mode, pp.mode);
        check("paddle1_vpos", paddle1_vpos, pp.p0);
        check("paddle2_vpos", paddle2_vpos, pp.p1);
      end
      if (reset) begin
        prev_coin = 0;
        hi_len    = 0;
        low_len   = -1;
      end else begin
        if (coin_sw && !prev_coin) begin
          rises++;
          if (exp_pulses.size() == 0) begin
            check("unexpected_pulse", 1, 0);
          end else begin
            pulse_t pe;
            pe = exp_pulses.pop_front();
            check("grant_id", grant_id, pe.grant);
            check("pulse_start_cycle", cyc, pe.start);
          end
          check("busy_in_pulse", busy, 1);
          if (low_len >= 0) check("gap_len_min", (low_len >= G + 1), 1);
          hi_len = 1;
        end else if (coin_sw) begin
          hi_len++;
        end else if (prev_coin) begin
          check("pulse_len", hi_len, P);
          check("busy_in_gap", busy, 1);
          low_len = 1;
        end else if (low_len >= 0) begin
          low_len++;
        end
        prev_coin = coin_sw;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  initial begin
    int base;
    cycles(3);
    @(negedge clk_sys);
    check("rst_coin_sw", coin_sw, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_dig_mode", dig_mode, 0);
    check("rst_paddle1", paddle1_vpos, 8'h80);
    check("rst_paddle2", paddle2_vpos, 8'h80);
    reset = 1'b0;
    cycles(5);

    // Single request held high: one pulse only.
    base = rises;
    req  = 4'b0100;
    cycles(20);
    check("single_pulse_count", rises - base, 1);
    check("single_grant_id", grant_id, 2);
    check("single_idle_busy", busy, 0);
    req = 4'b0000;
    cycles(3);

    // Simultaneous edges: grant 1 then 3.
    base = rises;
    req  = 4'b1010;
    cycles(30);
    check("simul_pulse_count", rises - base, 2);
    check("simul_last_grant", grant_id, 3);
    req = 4'b0000;
    cycles(3);

    // Repeated edges on one source collapse into a single credit.
    base = rises;
    req  = 4'b0100;
    cycles(1);
    for (int k = 0; k < 3; k++) begin
      req = 4'b0000; cycles(1);
      req = 4'b0100; cycles(1);
    end
    cycles(30);
    check("collapse_pulse_count", rises - base, 2);
    req = 4'b0000;
    cycles(3);

    // Level held through reset release does not trigger.
    req   = 4'b0001;
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    base  = rises;
    cycles(20);
    check("held_through_reset", rises - base, 0);
    req = 4'b0000;
    cycles(3);

    // Reset during a pulse drops coin_sw and the pending credit.
    req = 4'b0010;
    cycles(2);
    req = 4'b0110;
    cycles(1);
    reset = 1'b1;
    cycles(1);
    @(negedge clk_sys);
    check("coin_after_reset", coin_sw, 0);
    check("busy_after_reset", busy, 0);
    reset = 1'b0;
    base  = rises;
    cycles(30);
    check("pending_lost", rises - base, 0);
    req = 4'b0000;
    cycles(3);

    // Digital ramp up to saturation at the top.
    ana0   = 8'h80;
    dig_up = 2'b01;
    cycles(300);
    @(negedge clk_sys);
    check("ramp_dig_mode", dig_mode[0], 1);
    check("ramp_saturated", paddle1_vpos, 8'h00);

    // Analog return threshold: 15 stays digital, 16 returns.
    dig_up = 2'b00;
    ana0   = 8'h8F;
    cycles(5);
    @(negedge clk_sys);
    check("below_thr_stays_dig", dig_mode[0], 1);
    ana0 = 8'h90;
    cycles(2);
    @(negedge clk_sys);
    check("thr_returns_analog", dig_mode[0], 0);
    check("thr_paddle_follows", paddle1_vpos, 8'h90);

    // Randomised traffic on all inputs, scored by the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req[$urandom_range(0, 3)] = ~req[$urandom_range(0, 3)];
      if ($urandom_range(0, 15) == 0) ana0 = 8'($urandom);
      if ($urandom_range(0, 15) == 0) ana1 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ana0 = ana0 + 8'($urandom_range(0, 2)) - 8'd1;
      if ($urandom_range(0, 31) == 0) dig_up = 2'($urandom);
      if ($urandom_range(0, 31) == 0) dig_dn = 2'($urandom);
      reset = ($urandom_range(0, 799) == 0);
      cycles(1);
    end

    reset  = 1'b0;
    req    = 4'b0000;
    dig_up = 2'b00;
    dig_dn = 2'b00;
    cycles(40);
    @(negedge clk_sys);
    check("pulse_queue_drained", exp_pulses.size(), 0);
    check("final_busy", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
